// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module  : hazard_stall_controller
// Purpose : Stall/bubble/flush sequencing for load-use, taken branches and
//           multi-cycle EX operations, with saturating performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_ex_rd,
   input  logic             id_ex_MemRead,
   input  logic             ex_branch_taken,
   input  logic             ex_is_mc,
   input  logic             mc_done,
   input  logic             counters_clr,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_bubble,
   output logic             mc_start,
   output logic             mc_error,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = $clog2(MC_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              load_use;
   logic              wait_last;

   assign load_use  = id_ex_MemRead && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (id_ex_rd == id_rs2)));
   assign wait_last = (wait_cnt == WAIT_LAST);

   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      mc_start      = 1'b0;
      if (!rst_n) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_bubble = 1'b1;
      end else if (state == RUN) begin
         if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (ex_is_mc) begin
            mc_start      = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end else begin
         // A timed-out result is dropped: enables release but the bubble stays.
         ex_mem_bubble = !mc_done;
         if (!mc_done && !wait_last) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= RUN;
         wait_cnt     <= '0;
         mc_error     <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (state == RUN) begin
            wait_cnt <= '0;
            if (!ex_branch_taken && ex_is_mc) begin
               state <= MC_BUSY;
            end
         end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (mc_done) begin
               state <= RUN;
            end else if (wait_last) begin
               state    <= RUN;
               mc_error <= 1'b1;
            end
         end

         if (counters_clr) begin
            stall_cycles <= '0;
         end else if (!pc_write && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end

         if (counters_clr) begin
            flush_count <= '0;
         end else if ((state == RUN) && ex_branch_taken && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module  : tb_hazard_stall_controller
// Purpose : Directed vector table plus multi-cycle sequences for the stall
//           controller; dut_a uses default parameters, dut_b MC_TIMEOUT=4/CNT_W=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

   // Control vector order: {pc_write, if_id_write, id_ex_write, if_id_flush,
   //                        id_ex_flush, ex_mem_bubble, mc_start}
   localparam logic [6:0] CTL_RUN  = 7'b111_0000;
   localparam logic [6:0] CTL_LU   = 7'b001_0100;
   localparam logic [6:0] CTL_BR   = 7'b111_1100;
   localparam logic [6:0] CTL_MCS  = 7'b000_0011;
   localparam logic [6:0] CTL_BUSY = 7'b000_0010;
   localparam logic [6:0] CTL_TO   = 7'b111_0010;
   localparam logic [6:0] CTL_RST  = 7'b000_1110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, id_uses_rs1, id_uses_rs2, id_ex_MemRead;
   logic       ex_branch_taken, ex_is_mc, mc_done, counters_clr;
   logic [4:0] id_rs1, id_rs2, id_ex_rd;

   logic        a_pw, a_ifw, a_idw, a_iff, a_idf, a_bub, a_mcs, a_err;
   logic        b_pw, b_ifw, b_idw, b_iff, b_idf, b_bub, b_mcs, b_err;
   logic [15:0] a_stall, a_flush;
   logic [3:0]  b_stall, b_flush;
   logic [6:0]  a_ctl, b_ctl;

   assign a_ctl = {a_pw, a_ifw, a_idw, a_iff, a_idf, a_bub, a_mcs};
   assign b_ctl = {b_pw, b_ifw, b_idw, b_iff, b_idf, b_bub, b_mcs};

   hazard_stall_controller #(.MC_TIMEOUT(64), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_MemRead(id_ex_MemRead), .ex_branch_taken(ex_branch_taken),
      .ex_is_mc(ex_is_mc), .mc_done(mc_done), .counters_clr(counters_clr),
      .pc_write(a_pw), .if_id_write(a_ifw), .id_ex_write(a_idw),
      .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_bubble(a_bub),
      .mc_start(a_mcs), .mc_error(a_err), .stall_cycles(a_stall), .flush_count(a_flush)
   );

   hazard_stall_controller #(.MC_TIMEOUT(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_MemRead(id_ex_MemRead), .ex_branch_taken(ex_branch_taken),
      .ex_is_mc(ex_is_mc), .mc_done(mc_done), .counters_clr(counters_clr),
      .pc_write(b_pw), .if_id_write(b_ifw), .id_ex_write(b_idw),
      .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_bubble(b_bub),
      .mc_start(b_mcs), .mc_error(b_err), .stall_cycles(b_stall), .flush_count(b_flush)
   );

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, br;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[10];
   int   checks   = 0;
   int   failures = 0;
   int   exp_stall, exp_flush;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_MemRead = 1'b0;
      ex_branch_taken = 1'b0; ex_is_mc = 1'b0; mc_done = 1'b0; counters_clr = 1'b0;
   endtask

   task automatic load_use_x5();
      idle();
      id_ex_rd = 5'd5; id_ex_MemRead = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk); idle(); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{5'd0,  5'd5,  5'd5,  1'b0, 1'b1, 1'b1, 1'b0, CTL_LU};
      vecs[1] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, CTL_RUN};
      vecs[2] = '{5'd3,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, 1'b0, CTL_RUN};
      vecs[3] = '{5'd7,  5'd2,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, CTL_LU};
      vecs[4] = '{5'd7,  5'd0,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, CTL_RUN};
      vecs[5] = '{5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1, CTL_BR};
      vecs[6] = '{5'd1,  5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, CTL_LU};
      vecs[7] = '{5'd5,  5'd6,  5'd4,  1'b1, 1'b1, 1'b1, 1'b0, CTL_RUN};
      vecs[8] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, CTL_BR};
      vecs[9] = '{5'd12, 5'd12, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, CTL_RUN};

      idle();
      rst_n = 1'b0;
      #1;
      check("rst_forced_ctl_a", 32'(a_ctl), 32'(CTL_RST));
      check("rst_forced_ctl_b", 32'(b_ctl), 32'(CTL_RST));
      @(negedge clk);
      check("rst_stall_a", 32'(a_stall), 0);
      check("rst_flush_a", 32'(a_flush), 0);
      check("rst_err_a", 32'(a_err), 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_ctl_a", 32'(a_ctl), 32'(CTL_RUN));

      // Single-cycle hazard table
      exp_stall = 0;
      exp_flush = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         idle();
         id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; id_ex_rd = vecs[i].rd;
         id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
         id_ex_MemRead = vecs[i].mr; ex_branch_taken = vecs[i].br;
         #1;
         check($sformatf("vec%0d_ctl_a", i), 32'(a_ctl), 32'(vecs[i].exp));
         check($sformatf("vec%0d_ctl_b", i), 32'(b_ctl), 32'(vecs[i].exp));
         if (!vecs[i].exp[6]) exp_stall++;
         if (vecs[i].br) exp_flush++;
      end
      @(negedge clk); idle(); #1;
      check("table_stall_a", 32'(a_stall), 32'(exp_stall));
      check("table_flush_a", 32'(a_flush), 32'(exp_flush));

      // Branch wins over a simultaneous load-use match
      do_reset();
      load_use_x5(); ex_branch_taken = 1'b1; #1;
      check("br_vs_lu_ctl", 32'(a_ctl), 32'(CTL_BR));
      @(negedge clk); idle(); #1;
      check("br_flush_cnt", 32'(a_flush), 1);
      check("br_no_stall", 32'(a_stall), 0);

      // Load-use stall lasts one cycle
      @(negedge clk); load_use_x5(); #1;
      check("lu_ctl", 32'(a_ctl), 32'(CTL_LU));
      @(negedge clk); idle(); #1;
      check("lu_release", 32'(a_ctl), 32'(CTL_RUN));
      check("lu_stall_cnt", 32'(a_stall), 1);

      // Multi-cycle op, done 5 cycles after start
      do_reset();
      ex_is_mc = 1'b1; #1;
      check("mc_start_ctl", 32'(a_ctl), 32'(CTL_MCS));
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); ex_is_mc = 1'b0; #1;
         check($sformatf("mc_busy%0d", k), 32'(a_ctl), 32'(CTL_BUSY));
      end
      @(negedge clk); mc_done = 1'b1; #1;
      check("mc_done_ctl", 32'(a_ctl), 32'(CTL_RUN));
      @(negedge clk); mc_done = 1'b0; #1;
      check("mc_after_ctl", 32'(a_ctl), 32'(CTL_RUN));
      check("mc_stall_cnt", 32'(a_stall), 5);
      check("mc_no_err", 32'(a_err), 0);

      // Timeout on dut_b (MC_TIMEOUT = 4)
      do_reset();
      ex_is_mc = 1'b1; #1;
      check("to_start_b", 32'(b_ctl), 32'(CTL_MCS));
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); ex_is_mc = 1'b0; #1;
         check($sformatf("to_busy%0d_b", k), 32'(b_ctl), 32'(CTL_BUSY));
      end
      @(negedge clk); #1;
      check("to_release_b", 32'(b_ctl), 32'(CTL_TO));
      check("to_err_not_yet", 32'(b_err), 0);
      @(negedge clk); #1;
      check("to_run_b", 32'(b_ctl), 32'(CTL_RUN));
      check("to_err_set", 32'(b_err), 1);
      @(negedge clk); mc_done = 1'b1; #1;
      check("spurious_done_b", 32'(b_ctl), 32'(CTL_RUN));
      @(negedge clk); mc_done = 1'b0; #1;
      check("spurious_after_b", 32'(b_ctl), 32'(CTL_RUN));
      check("to_err_held", 32'(b_err), 1);
      check("to_stall_cnt_b", 32'(b_stall), 4);

      // Reset asserted mid-stall
      @(negedge clk); ex_is_mc = 1'b1; #1;
      check("mid_start_a", 32'(a_ctl), 32'(CTL_MCS));
      @(negedge clk); ex_is_mc = 1'b0; #1;
      check("mid_busy_a", 32'(a_ctl), 32'(CTL_BUSY));
      @(negedge clk); rst_n = 1'b0; #1;
      check("mid_rst_ctl_a", 32'(a_ctl), 32'(CTL_RST));
      check("mid_rst_ctl_b", 32'(b_ctl), 32'(CTL_RST));
      @(negedge clk); rst_n = 1'b1; #1;
      check("mid_after_ctl_a", 32'(a_ctl), 32'(CTL_RUN));
      check("mid_after_ctl_b", 32'(b_ctl), 32'(CTL_RUN));
      check("mid_stall_a", 32'(a_stall), 0);
      check("mid_err_a", 32'(a_err), 0);
      check("mid_err_b", 32'(b_err), 0);

      // Saturation (dut_b is 4 bits wide) and clear priority
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); load_use_x5();
      end
      @(negedge clk); idle(); #1;
      check("sat_stall_b", 32'(b_stall), 15);
      check("sat_stall_a", 32'(a_stall), 20);
      @(negedge clk); load_use_x5(); counters_clr = 1'b1; #1;
      @(negedge clk); idle(); #1;
      check("clr_stall_b", 32'(b_stall), 0);
      check("clr_stall_a", 32'(a_stall), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
